// File: rtl/vram_fetch_sched.sv
// Video memory scheduler: fetches the next visible row into the idle line-buffer bank during
// horizontal blank, and gives the remaining memory cycles to a host port.
module vram_fetch_sched #(
  parameter int unsigned LINE_WORDS = 200,
  parameter int unsigned V_VISIBLE  = 600,
  parameter int unsigned V_TOTAL    = 628,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LB_AW      = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_hvis,
  input  logic [15:0]       i_vcount,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_re,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_lb_we,
  output logic [LB_AW-1:0]  o_lb_addr,
  output logic [DATA_W-1:0] o_lb_wdata,
  output logic              o_lb_bank,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_ack,
  output logic              o_host_rvalid,
  output logic [DATA_W-1:0] o_host_rdata,
  output logic              o_underrun
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  localparam logic [LB_AW-1:0]  LastIdx   = LB_AW'(LINE_WORDS - 1);
  localparam logic [15:0]       LastLine  = 16'(V_TOTAL - 1);
  localparam logic [15:0]       VisLines  = 16'(V_VISIBLE);
  localparam logic [ADDR_W-1:0] LineStep  = ADDR_W'(LINE_WORDS);

  state_e            r_state, w_state_next;
  logic              r_hvis_d;
  logic [ADDR_W-1:0] r_base;
  logic [LB_AW-1:0]  r_idx;
  logic              r_lb_pend;
  logic [LB_AW-1:0]  r_lb_addr;
  logic              r_lb_bank;
  logic              r_underrun;
  logic              r_rvalid;

  logic              w_fall, w_rise;
  logic [15:0]       w_target;
  logic              w_start, w_abort, w_grant, w_fetch_issue;
  logic [ADDR_W-1:0] w_next_base;

  assign w_fall      = r_hvis_d & ~i_hvis;
  assign w_rise      = ~r_hvis_d & i_hvis;
  assign w_target    = (i_vcount == LastLine) ? 16'd0 : i_vcount + 16'd1;
  // Reset gating keeps every strobe quiet while nrst is held low.
  assign w_start     = nrst & w_fall & (r_state == StIdle) & (w_target < VisLines);
  assign w_next_base = (w_target == 16'd0) ? '0 : r_base + LineStep;
  assign w_abort     = w_rise & (r_state != StIdle);
  assign w_grant     = nrst & (r_state == StIdle) & ~w_start & i_host_req;
  assign w_fetch_issue = (r_state == StFetch) & ~w_abort;

  always_comb begin
    w_state_next = r_state;
    o_mem_re     = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_host_ack   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_next = StFetch;
        end else if (w_grant) begin
          o_host_ack  = 1'b1;
          o_mem_re    = ~i_host_we;
          o_mem_we    = i_host_we;
          o_mem_addr  = i_host_addr;
          o_mem_wdata = i_host_we ? i_host_wdata : '0;
        end
      end
      StFetch: begin
        if (w_abort) begin
          w_state_next = StIdle;
        end else begin
          o_mem_re   = 1'b1;
          o_mem_addr = r_base + ADDR_W'(r_idx);
          if (r_idx == LastIdx) w_state_next = StDrain;
        end
      end
      StDrain: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // A rise that aborts a fetch also drops the write of the word returned this cycle.
  assign o_lb_we       = r_lb_pend & ~w_abort;
  assign o_lb_addr     = o_lb_we ? r_lb_addr : '0;
  assign o_lb_wdata    = o_lb_we ? i_mem_rdata : '0;
  assign o_lb_bank     = r_lb_bank;
  assign o_underrun    = r_underrun;
  assign o_host_rvalid = r_rvalid;
  assign o_host_rdata  = r_rvalid ? i_mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state    <= StIdle;
      r_hvis_d   <= 1'b1;
      r_base     <= '0;
      r_idx      <= '0;
      r_lb_pend  <= 1'b0;
      r_lb_addr  <= '0;
      r_lb_bank  <= 1'b0;
      r_underrun <= 1'b0;
      r_rvalid   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_hvis_d  <= i_hvis;
      r_rvalid  <= w_grant & ~i_host_we;
      r_lb_pend <= w_fetch_issue;
      if (w_start) begin
        r_base <= w_next_base;
        r_idx  <= '0;
      end else if (w_fetch_issue) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_fetch_issue) r_lb_addr <= r_idx;
      if (w_abort) r_underrun <= 1'b1;
      else if (w_rise) r_lb_bank <= ~r_lb_bank;
    end
  end

endmodule
